// File: rtl/mult_sched_pkg.sv
// Shared constants for the multiplier scheduler: operand width and FSM state encoding.
package mult_sched_pkg;

   localparam int unsigned OP_W = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      RUN    = 3'd2,
      SETTLE = 3'd3,
      DONE   = 3'd4
   } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
   parameter  int unsigned NUM_REQ = 4,
   localparam int unsigned IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic [IW-1:0]      grant,
   output logic               valid
);

   int unsigned idx;
   logic [IW-1:0] sel;

   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = 0;
      sel   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         idx = 32'(ptr) + i;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end
         sel = IW'(idx);
         if (!valid && req[sel]) begin
            valid = 1'b1;
            grant = sel;
         end
      end
   end

endmodule

// File: rtl/mult_sched.sv
// Shares one 8-bit multiplier among NUM_REQ requesters with a req/ack handshake.
// Optional RUN timeout with err output is enabled by defining MULT_SCHED_TIMEOUT_EN.
module mult_sched
   import mult_sched_pkg::*;
#(
   parameter  int unsigned NUM_REQ    = 4,
   parameter  int unsigned SETTLE_CYC = 1,
   parameter  int unsigned MAX_CYC    = 15,
   localparam int unsigned IW         = $clog2(NUM_REQ)
) (
   input  logic                    Clk,
   input  logic                    Reset,
`ifdef MULT_SCHED_TIMEOUT_EN
   output logic                    err,
`endif
   input  logic [NUM_REQ-1:0]      req,
   input  logic [OP_W*NUM_REQ-1:0] a_in,
   input  logic [OP_W*NUM_REQ-1:0] b_in,
   output logic [NUM_REQ-1:0]      ack,
   output logic [OP_W-1:0]         result,
   output logic                    sat,
   output logic [IW-1:0]           grant_id,
   output logic                    busy,
   output logic [OP_W-1:0]         mul_a,
   output logic [OP_W-1:0]         mul_b,
   output logic                    mul_rst,
   input  logic [OP_W-1:0]         mul_p,
   input  logic                    mul_fim,
   input  logic                    mul_sat
);

   state_t          state_q, state_d;
   logic [IW-1:0]   rr_ptr_q, rr_next;
   logic [IW-1:0]   grant_id_q;
   logic [OP_W-1:0] mul_a_q, mul_b_q;
   logic [OP_W-1:0] result_q, cap_result;
   logic            sat_q, cap_sat;
   logic [1:0]      settle_q, settle_d;
   logic            latch, capture;
   logic [IW-1:0]   arb_grant;
   logic            arb_valid;

`ifdef MULT_SCHED_TIMEOUT_EN
   logic [7:0]      run_cnt_q, run_cnt_d;
   logic            err_q, err_d;
`endif

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .req   (req),
      .ptr   (rr_ptr_q),
      .grant (arb_grant),
      .valid (arb_valid)
   );

   always_comb begin
      if (grant_id_q == IW'(NUM_REQ - 1)) begin
         rr_next = '0;
      end else begin
         rr_next = grant_id_q + 1'b1;
      end
   end

   always_comb begin
      state_d    = state_q;
      settle_d   = settle_q;
      latch      = 1'b0;
      capture    = 1'b0;
      cap_result = mul_p;
      cap_sat    = mul_sat;
`ifdef MULT_SCHED_TIMEOUT_EN
      run_cnt_d  = run_cnt_q;
      err_d      = err_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (arb_valid) begin
               latch   = 1'b1;
               state_d = LOAD;
            end
         end
         LOAD: begin
`ifdef MULT_SCHED_TIMEOUT_EN
            run_cnt_d = '0;
`endif
            state_d = RUN;
         end
         RUN: begin
            if (mul_fim) begin
               if (SETTLE_CYC == 0) begin
                  capture = 1'b1;
                  state_d = DONE;
               end else begin
                  settle_d = '0;
                  state_d  = SETTLE;
               end
`ifdef MULT_SCHED_TIMEOUT_EN
            end else if (run_cnt_q == 8'(MAX_CYC - 1)) begin
               // Give up on the multiplier: report a saturated zero and flag it.
               capture    = 1'b1;
               cap_result = '0;
               cap_sat    = 1'b1;
               err_d      = 1'b1;
               state_d    = DONE;
            end else begin
               run_cnt_d = run_cnt_q + 8'd1;
`endif
            end
         end
         SETTLE: begin
            if (32'(settle_q) + 1 >= SETTLE_CYC) begin
               capture = 1'b1;
               state_d = DONE;
            end else begin
               settle_d = settle_q + 2'd1;
            end
         end
         DONE: begin
`ifdef MULT_SCHED_TIMEOUT_EN
            err_d = 1'b0;
`endif
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         grant_id_q <= '0;
         mul_a_q    <= '0;
         mul_b_q    <= '0;
         result_q   <= '0;
         sat_q      <= 1'b0;
         settle_q   <= '0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         if (latch) begin
            grant_id_q <= arb_grant;
            mul_a_q    <= a_in[arb_grant*OP_W +: OP_W];
            mul_b_q    <= b_in[arb_grant*OP_W +: OP_W];
         end
         if (capture) begin
            result_q <= cap_result;
            sat_q    <= cap_sat;
         end
         if (state_q == DONE) begin
            rr_ptr_q <= rr_next;
         end
      end
   end

`ifdef MULT_SCHED_TIMEOUT_EN
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         run_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         run_cnt_q <= run_cnt_d;
         err_q     <= err_d;
      end
   end

   assign err = err_q;
`endif

   // Decoded from state so reset drives mul_rst high without waiting for a clock.
   always_comb begin
      ack = '0;
      if (state_q == DONE) begin
         ack[grant_id_q] = 1'b1;
      end
   end

   assign mul_rst  = (state_q == IDLE) || (state_q == LOAD) || (state_q == DONE);
   assign busy     = (state_q != IDLE);
   assign result   = result_q;
   assign sat      = sat_q;
   assign grant_id = grant_id_q;
   assign mul_a    = mul_a_q;
   assign mul_b    = mul_b_q;

endmodule
